alu_operand_regs: RTL and testbench

ALU_OPERAND_REGS -- requirements
Module: alu_operand_regs

---
 rtl/alu_operand_regs.sv | 135 +++++++++++++
 tb/tb_alu_operand_regs.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_regs.sv
// Operand/accumulator register block feeding an external combinational ALU.
// LDA/LDB load A/B directly; ADD/SUB run IDLE -> EXEC -> WB and write the result back into A.
module alu_operand_regs #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_sub,
   input  logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] acc,
   output logic             carry,
   output logic             zero,
   output logic             done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] WB   = 2'd2;

   localparam logic [1:0] OP_LDA = 2'b00;
   localparam logic [1:0] OP_LDB = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;
   logic             accept_s;

   // Carry out of A+B, or of A+~B+1 for subtract (1 = no borrow, A >= B).
   function automatic logic carry_out(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic             sub);
      logic [WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, sub};
      return sum[WIDTH];
   endfunction

   assign cmd_ready = (state_q == IDLE) && !rst;
   assign accept_s  = cmd_valid && cmd_ready;

   assign alu_a   = a_q;
   assign alu_b   = b_q;
   assign alu_sub = sub_q;
   assign acc     = a_q;
   assign carry   = carry_q;
   assign zero    = zero_q;
   assign done    = done_q;

   // Next-state and register update logic.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               case (cmd_op)
                  OP_LDA: begin
                     a_d    = bus_in;
                     done_d = 1'b1;
                  end
                  OP_LDB: begin
                     b_d    = bus_in;
                     done_d = 1'b1;
                  end
                  OP_ADD: begin
                     sub_d   = 1'b0;
                     state_d = EXEC;
                  end
                  OP_SUB: begin
                     sub_d   = 1'b1;
                     state_d = EXEC;
                  end
                  default: begin
                     state_d = IDLE;
                  end
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         // ALU settle cycle; nothing is written here.
         EXEC: begin
            state_d = WB;
         end
         WB: begin
            a_d     = alu_out;
            zero_d  = (alu_out == {WIDTH{1'b0}});
            carry_d = carry_out(a_q, b_q, sub_q);
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset that overrides any command.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_alu_operand_regs.sv
// Directed self-checking bench for alu_operand_regs with a behavioural downstream ALU.
module tb_alu_operand_regs;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] bus_in;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             alu_sub;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic             zero;
   logic             done;

   int n_chk;
   int n_bad;

   alu_operand_regs #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .bus_in    (bus_in),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sub   (alu_sub),
      .alu_out   (alu_out),
      .acc       (acc),
      .carry     (carry),
      .zero      (zero),
      .done      (done)
   );

   // Downstream combinational ALU, modulo 2^WIDTH.
   assign alu_out = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load command: accepted at the next edge, done visible right after it.
   task automatic load(input logic [1:0] op, input logic [7:0] data, input string tag);
      cmd_valid = 1'b1;
      cmd_op    = op;
      bus_in    = data;
      tick();
      cmd_valid = 1'b0;
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
      if (op == 2'b00) check_eq({tag, "_acc"}, 32'(acc), 32'(data));
      else             check_eq({tag, "_b"}, 32'(alu_b), 32'(data));
   endtask

   task automatic run_arith(input logic [1:0] op, input logic [7:0] exp_acc,
                            input logic exp_c, input logic exp_z, input string tag);
      logic exp_sub;
      exp_sub   = op[0];
      cmd_valid = 1'b1;
      cmd_op    = op;
      bus_in    = 8'd0;
      tick();
      cmd_valid = 1'b0;
      check_eq({tag, "_exec_rdy"}, 32'(cmd_ready), 32'd0);
      check_eq({tag, "_exec_sub"}, 32'(alu_sub), 32'(exp_sub));
      check_eq({tag, "_exec_done"}, 32'(done), 32'd0);
      tick();
      check_eq({tag, "_wb_rdy"}, 32'(cmd_ready), 32'd0);
      check_eq({tag, "_wb_sub"}, 32'(alu_sub), 32'(exp_sub));
      check_eq({tag, "_wb_done"}, 32'(done), 32'd0);
      tick();
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_acc"}, 32'(acc), 32'(exp_acc));
      check_eq({tag, "_carry"}, 32'(carry), 32'(exp_c));
      check_eq({tag, "_zero"}, 32'(zero), 32'(exp_z));
      check_eq({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
      tick();
      check_eq({tag, "_done_low"}, 32'(done), 32'd0);
   endtask

   initial begin
      n_chk     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      bus_in    = 8'd0;

      tick();
      tick();
      check_eq("rst_rdy", 32'(cmd_ready), 32'd0);
      check_eq("rst_acc", 32'(acc), 32'd0);
      check_eq("rst_b", 32'(alu_b), 32'd0);
      check_eq("rst_flags", {30'd0, carry, zero}, 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_sub", 32'(alu_sub), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("rst_release_rdy", 32'(cmd_ready), 32'd1);

      // 45 + 10
      load(2'b00, 8'd45, "t1_lda");
      load(2'b01, 8'd10, "t1_ldb");
      run_arith(2'b10, 8'd55, 1'b0, 1'b0, "t1_add");

      // 31 - 11
      load(2'b00, 8'd31, "t2_lda");
      load(2'b01, 8'd11, "t2_ldb");
      run_arith(2'b11, 8'd20, 1'b1, 1'b0, "t2_sub");

      // 10 - 20 wraps to 246 with borrow
      load(2'b00, 8'd10, "t3_lda");
      load(2'b01, 8'd20, "t3_ldb");
      run_arith(2'b11, 8'd246, 1'b0, 1'b0, "t3_sub");

      // 200 + 56 wraps to 0; a load leaves flags alone; then accumulate 0 + 56
      load(2'b00, 8'd200, "t4_lda");
      load(2'b01, 8'd56, "t4_ldb");
      run_arith(2'b10, 8'd0, 1'b1, 1'b1, "t4_add1");
      load(2'b01, 8'd56, "t4_ldb2");
      check_eq("t4_keep_carry", 32'(carry), 32'd1);
      check_eq("t4_keep_zero", 32'(zero), 32'd1);
      run_arith(2'b10, 8'd56, 1'b0, 1'b0, "t4_add2");

      // LDA 99 held valid during EXEC/WB is ignored
      load(2'b00, 8'd1, "t5_lda");
      load(2'b01, 8'd2, "t5_ldb");
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      tick();
      cmd_op    = 2'b00;
      bus_in    = 8'd99;
      check_eq("t5_exec_rdy", 32'(cmd_ready), 32'd0);
      tick();
      check_eq("t5_wb_rdy", 32'(cmd_ready), 32'd0);
      check_eq("t5_wb_acc", 32'(acc), 32'd1);
      tick();
      cmd_valid = 1'b0;
      check_eq("t5_done", 32'(done), 32'd1);
      check_eq("t5_acc", 32'(acc), 32'd3);
      tick();
      check_eq("t5_acc_hold", 32'(acc), 32'd3);
      check_eq("t5_done_low", 32'(done), 32'd0);

      // Reset during EXEC aborts the add
      load(2'b00, 8'd5, "t6_lda");
      load(2'b01, 8'd3, "t6_ldb");
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      tick();
      cmd_valid = 1'b0;
      rst       = 1'b1;
      #1;
      check_eq("t6_rst_rdy", 32'(cmd_ready), 32'd0);
      tick();
      check_eq("t6_acc", 32'(acc), 32'd0);
      check_eq("t6_b", 32'(alu_b), 32'd0);
      check_eq("t6_flags", {30'd0, carry, zero}, 32'd0);
      check_eq("t6_done", 32'(done), 32'd0);
      check_eq("t6_sub", 32'(alu_sub), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("t6_rdy_after", 32'(cmd_ready), 32'd1);
      tick();
      check_eq("t6_no_done", 32'(done), 32'd0);
      check_eq("t6_acc_after", 32'(acc), 32'd0);
      tick();
      check_eq("t6_no_done2", 32'(done), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
